// File: rtl/eu_fetch_unit.sv
// eu_fetch_unit: PC/IR front end that fetches instructions over a ready-handshaked
// memory port with a wait-state timeout, and applies absolute/relative/conditional PC loads.
module eu_fetch_unit #(
    parameter int              DW       = 16,
    parameter int              OFFW     = 8,
    parameter int              MAX_WAIT = 4,
    parameter logic [DW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fetch_req,
    input  logic          mem_rdy,
    input  logic [DW-1:0] mem_din,
    input  logic [DW-1:0] alu_in,
    input  logic [DW-1:0] reg_addr,
    input  logic          addr_sel,
    input  logic          pc_ld,
    input  logic          pc_sel,
    input  logic [1:0]    cond,
    input  logic          C,
    input  logic          N,
    input  logic          Z,
    output logic [DW-1:0] addr_out,
    output logic          mem_rd,
    output logic [DW-1:0] pc_q,
    output logic [DW-1:0] ir_q,
    output logic          ir_valid,
    output logic          fault,
    output logic          busy
);
    localparam int WW = $clog2(MAX_WAIT) + 1;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t        state, state_n;
    logic [WW-1:0] wcnt, wcnt_n;
    logic [DW-1:0] pc_n, ir_n, rel_off, target;
    logic          ir_valid_n, fault_n, cond_ok;

    // Size cast of a signed operand sign-extends, which also covers OFFW == DW
    assign rel_off = DW'($signed(ir_q[OFFW-1:0]));
    assign target  = pc_sel ? alu_in : pc_q + rel_off;
    assign cond_ok = cond[1] ? (cond[0] ? C : N) : (cond[0] ? Z : 1'b1);

    assign busy     = state == FETCH;
    assign mem_rd   = state == FETCH;
    assign addr_out = (state == IDLE && addr_sel) ? reg_addr : pc_q;

    always_comb begin
        state_n    = state;
        pc_n       = pc_q;
        ir_n       = ir_q;
        wcnt_n     = wcnt;
        ir_valid_n = 1'b0;
        fault_n    = 1'b0;
        if (state == IDLE) begin
            if (fetch_req) begin
                state_n = FETCH;
                wcnt_n  = '0;
            end else if (pc_ld && cond_ok) begin
                pc_n = target;
            end
        end else if (mem_rdy) begin
            ir_n       = mem_din;
            pc_n       = pc_q + DW'(1);
            ir_valid_n = 1'b1;
            state_n    = IDLE;
        end else if (wcnt == WW'(MAX_WAIT - 1)) begin
            fault_n = 1'b1;
            state_n = IDLE;
        end else begin
            wcnt_n = wcnt + WW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            wcnt     <= '0;
            ir_valid <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state    <= state_n;
            pc_q     <= pc_n;
            ir_q     <= ir_n;
            wcnt     <= wcnt_n;
            ir_valid <= ir_valid_n;
            fault    <= fault_n;
        end
    end
endmodule

// File: tb/tb_eu_fetch_unit.sv
// tb_eu_fetch_unit: directed test-plan scenarios plus randomized traffic,
// each cycle compared against a transaction-level reference model.
module tb_eu_fetch_unit;
    localparam int          DW       = 16;
    localparam int          MAX_WAIT = 4;
    localparam logic [15:0] RPC      = 16'h0010;

    logic        clk = 1'b0;
    logic        reset, fetch_req, mem_rdy, addr_sel, pc_ld, pc_sel, C, N, Z;
    logic [15:0] mem_din, alu_in, reg_addr;
    logic [1:0]  cond;
    logic [15:0] addr_out, pc_q, ir_q;
    logic        mem_rd, ir_valid, fault, busy;

    int n_chk = 0;
    int n_fail = 0;

    logic [15:0] m_pc, m_ir;
    bit          m_busy, m_irv, m_fault;
    int          m_waits;

    eu_fetch_unit #(.DW(DW), .OFFW(8), .MAX_WAIT(MAX_WAIT), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .mem_rdy(mem_rdy),
        .mem_din(mem_din), .alu_in(alu_in), .reg_addr(reg_addr), .addr_sel(addr_sel),
        .pc_ld(pc_ld), .pc_sel(pc_sel), .cond(cond), .C(C), .N(N), .Z(Z),
        .addr_out(addr_out), .mem_rd(mem_rd), .pc_q(pc_q), .ir_q(ir_q),
        .ir_valid(ir_valid), .fault(fault), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        fetch_req = 0; mem_rdy = 0; mem_din = '0; alu_in = '0; reg_addr = '0;
        addr_sel = 0; pc_ld = 0; pc_sel = 0; cond = 2'b00; C = 0; N = 0; Z = 0;
    endtask

    task automatic model_reset();
        m_pc = RPC; m_ir = '0; m_busy = 0; m_irv = 0; m_fault = 0; m_waits = 0;
    endtask

    function automatic bit cond_true();
        case (cond)
            2'b00:   return 1'b1;
            2'b01:   return Z;
            2'b10:   return N;
            default: return C;
        endcase
    endfunction

    // Advance the model by one clock edge from the currently driven inputs
    task automatic model_next();
        int off;
        if (!reset) begin
            model_reset();
            return;
        end
        m_irv = 0;
        m_fault = 0;
        if (!m_busy) begin
            if (fetch_req) begin
                m_busy = 1;
                m_waits = 0;
            end else if (pc_ld && cond_true()) begin
                if (pc_sel) m_pc = alu_in;
                else begin
                    off = int'(m_ir[7:0]);
                    if (off > 127) off -= 256;
                    m_pc = 16'((int'(m_pc) + off + 65536) % 65536);
                end
            end
        end else if (mem_rdy) begin
            m_ir = mem_din;
            m_pc = 16'((int'(m_pc) + 1) % 65536);
            m_irv = 1;
            m_busy = 0;
        end else begin
            m_waits++;
            if (m_waits == MAX_WAIT) begin
                m_fault = 1;
                m_busy = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("pc_q", pc_q, m_pc);
        check("ir_q", ir_q, m_ir);
        check("busy", busy, m_busy);
        check("mem_rd", mem_rd, m_busy);
        check("ir_valid", ir_valid, m_irv);
        check("fault", fault, m_fault);
        check("addr_out", addr_out, (!m_busy && addr_sel) ? reg_addr : m_pc);
    endtask

    task automatic step();
        model_next();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic load_abs(input logic [15:0] t);
        idle_inputs(); pc_ld = 1; pc_sel = 1; alu_in = t; step(); idle_inputs();
    endtask

    task automatic fetch(input logic [15:0] din, input int waits);
        idle_inputs(); fetch_req = 1; step(); idle_inputs();
        repeat (waits) step();
        mem_rdy = 1; mem_din = din; step(); idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("rst_pc", pc_q, 16'h0010);
        reset = 1;

        load_abs(16'h0020);
        check("pc_abs", pc_q, 16'h0020);
        fetch_req = 1; step(); idle_inputs();
        addr_sel = 1; reg_addr = 16'hBEEF; pc_ld = 1; pc_sel = 1; alu_in = 16'h5555;
        #1 check("fetch_addr", addr_out, 16'h0020);
        check("fetch_busy", busy, 1);
        step();
        mem_rdy = 1; mem_din = 16'h1234; step();
        check("f0_ir", ir_q, 16'h1234);
        check("f0_pc", pc_q, 16'h0021);
        check("f0_valid", ir_valid, 1);
        idle_inputs(); step();
        check("f0_valid_off", ir_valid, 0);
        addr_sel = 1; reg_addr = 16'hA5A5;
        #1 check("idle_reg_addr", addr_out, 16'hA5A5);

        load_abs(16'h0020);
        fetch(16'h1234, 2);
        check("f2_ir", ir_q, 16'h1234);
        check("f2_pc", pc_q, 16'h0021);
        check("f2_valid", ir_valid, 1);

        fetch_req = 1; step(); idle_inputs();
        repeat (MAX_WAIT) step();
        check("to_fault", fault, 1);
        check("to_pc", pc_q, 16'h0021);
        check("to_ir", ir_q, 16'h1234);
        step();
        check("to_fault_off", fault, 0);
        fetch(16'h4321, MAX_WAIT - 1);
        check("to_late_fault", fault, 0);
        check("to_late_valid", ir_valid, 1);
        check("to_late_ir", ir_q, 16'h4321);

        load_abs(16'h0001);
        fetch(16'h00FC, 0);
        check("rel_pre_pc", pc_q, 16'h0002);
        pc_ld = 1; pc_sel = 0; cond = 2'b00; step(); idle_inputs();
        check("rel_wrap", pc_q, 16'hFFFE);
        load_abs(16'hFFFF);
        fetch(16'h0000, 0);
        check("inc_wrap", pc_q, 16'h0000);

        pc_ld = 1; pc_sel = 1; alu_in = 16'h0400; cond = 2'b01; Z = 0; step();
        check("cond_z0", pc_q, 16'h0000);
        Z = 1; step();
        check("cond_z1", pc_q, 16'h0400);
        cond = 2'b10; N = 0; alu_in = 16'h0555; step();
        check("cond_n0", pc_q, 16'h0400);
        cond = 2'b11; C = 1; alu_in = 16'h0777; step(); idle_inputs();
        check("cond_c1", pc_q, 16'h0777);

        fetch_req = 1; pc_ld = 1; pc_sel = 1; alu_in = 16'h1111; step(); idle_inputs();
        check("prio_busy", busy, 1);
        check("prio_pc", pc_q, 16'h0777);
        mem_rdy = 1; mem_din = 16'h9999; step(); idle_inputs();
        check("prio_done_pc", pc_q, 16'h0778);

        fetch_req = 1; step(); idle_inputs(); step();
        #2 reset = 0;
        model_reset();
        #1;
        check("async_pc", pc_q, 16'h0010);
        check("async_ir", ir_q, 16'h0000);
        check("async_mem_rd", mem_rd, 0);
        check("async_busy", busy, 0);
        step();
        reset = 1;
        step();
        check("post_rst_busy", busy, 0);

        for (int i = 0; i < 3000; i++) begin
            fetch_req = ($urandom_range(0, 2) == 0);
            mem_rdy   = ($urandom_range(0, 2) == 0);
            mem_din   = 16'($urandom);
            alu_in    = 16'($urandom);
            reg_addr  = 16'($urandom);
            addr_sel  = 1'($urandom);
            pc_ld     = 1'($urandom);
            pc_sel    = 1'($urandom);
            cond      = 2'($urandom);
            C = 1'($urandom); N = 1'($urandom); Z = 1'($urandom);
            reset     = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
